// File: rtl/rpn_stack_alu.sv
// RPN calculator core: DEPTH-entry N-bit operand stack with ALU opcodes and flags.
// Define RPN_UNDO_EN to build the one-level undo history (shadow stack, depth, flags).
module rpn_stack_alu #(
   parameter int N     = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       Enter_pulse,
   input  logic                       Undo_pulse,
   input  logic                       OpSel,
   input  logic [N-1:0]               DataIn,
   output logic [N-1:0]               Top,
   output logic [$clog2(DEPTH+1)-1:0] Depth,
   output logic [3:0]                 Flags,
   output logic                       Error
);

   localparam int DW = $clog2(DEPTH+1);
   localparam logic [DW-1:0] FULL = DW'(DEPTH);
   localparam logic [DW-1:0] TWO  = DW'(2);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_DUP  = 4'd5,
      OP_SWAP = 4'd6,
      OP_DROP = 4'd7
   } opcode_t;

   logic [DEPTH-1:0][N-1:0] r_stack;
   logic [DW-1:0]           r_depth;
   logic [3:0]              r_flags;
   logic                    r_error;

   logic [DEPTH-1:0][N-1:0] w_nextStack;
   logic [DW-1:0]           w_nextDepth;
   logic [3:0]              w_nextFlags;
   logic                    w_accept;
   logic                    w_restore;
   logic                    w_reject;
   logic                    w_undo;
   logic                    w_histOk;
   logic [DEPTH-1:0][N-1:0] w_shStack;
   logic [DW-1:0]           w_shDepth;
   logic [3:0]              w_shFlags;

   logic [N-1:0]            w_a;
   logic [N-1:0]            w_b;
   logic [N:0]              w_add;
   logic [N:0]              w_sub;
   logic [N-1:0]            w_result;
   logic                    w_carry;
   logic                    w_ovf;
   logic [DEPTH-1:0][N-1:0] w_popped;
   opcode_t                 w_op;

`ifdef RPN_UNDO_EN
   logic [DEPTH-1:0][N-1:0] r_shStack;
   logic [DW-1:0]           r_shDepth;
   logic [3:0]              r_shFlags;
   logic                    r_histValid;

   assign w_undo    = Undo_pulse;
   assign w_histOk  = r_histValid;
   assign w_shStack = r_shStack;
   assign w_shDepth = r_shDepth;
   assign w_shFlags = r_shFlags;

   // Snapshot the pre-command state on every accepted Enter; an Undo consumes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shStack   <= '0;
         r_shDepth   <= '0;
         r_shFlags   <= '0;
         r_histValid <= 1'b0;
      end else if (w_accept) begin
         r_shStack   <= r_stack;
         r_shDepth   <= r_depth;
         r_shFlags   <= r_flags;
         r_histValid <= 1'b1;
      end else if (w_restore) begin
         r_histValid <= 1'b0;
      end
   end
`else
   logic w_unusedUndo;

   assign w_unusedUndo = Undo_pulse;
   assign w_undo       = 1'b0;
   assign w_histOk     = 1'b0;
   assign w_shStack    = '0;
   assign w_shDepth    = '0;
   assign w_shFlags    = '0;
`endif

   assign w_a      = r_stack[1];
   assign w_b      = r_stack[0];
   assign w_add    = {1'b0, w_a} + {1'b0, w_b};
   assign w_sub    = {1'b0, w_a} + {1'b0, ~w_b} + (N+1)'(1);
   assign w_popped = {{N{1'b0}}, r_stack[DEPTH-1:1]};
   assign w_op     = opcode_t'(DataIn[3:0]);

   always_comb begin
      w_result = '0;
      w_carry  = 1'b0;
      w_ovf    = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_result = w_add[N-1:0];
            w_carry  = w_add[N];
            w_ovf    = (w_a[N-1] == w_b[N-1]) && (w_add[N-1] != w_a[N-1]);
         end
         OP_SUB: begin
            w_result = w_sub[N-1:0];
            w_carry  = w_sub[N];
            w_ovf    = (w_a[N-1] != w_b[N-1]) && (w_sub[N-1] != w_a[N-1]);
         end
         OP_AND:  w_result = w_a & w_b;
         OP_OR:   w_result = w_a | w_b;
         OP_XOR:  w_result = w_a ^ w_b;
         default: w_result = '0;
      endcase
   end

   // Undo takes priority over Enter; rejected commands only raise Error.
   always_comb begin
      w_nextStack = r_stack;
      w_nextDepth = r_depth;
      w_nextFlags = r_flags;
      w_accept    = 1'b0;
      w_restore   = 1'b0;
      w_reject    = 1'b0;
      if (w_undo) begin
         if (w_histOk) begin
            w_restore   = 1'b1;
            w_nextStack = w_shStack;
            w_nextDepth = w_shDepth;
            w_nextFlags = w_shFlags;
         end else begin
            w_reject = 1'b1;
         end
      end else if (Enter_pulse) begin
         if (!OpSel) begin
            if (r_depth == FULL) begin
               w_reject = 1'b1;
            end else begin
               w_accept    = 1'b1;
               w_nextStack = {r_stack[DEPTH-2:0], DataIn};
               w_nextDepth = r_depth + DW'(1);
            end
         end else begin
            case (w_op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  if (r_depth < TWO) begin
                     w_reject = 1'b1;
                  end else begin
                     w_accept       = 1'b1;
                     w_nextStack    = w_popped;
                     w_nextStack[0] = w_result;
                     w_nextDepth    = r_depth - DW'(1);
                     w_nextFlags    = {w_result[N-1], (w_result == '0), w_carry, w_ovf};
                  end
               end
               OP_DUP: begin
                  if (r_depth == FULL || r_depth == '0) begin
                     w_reject = 1'b1;
                  end else begin
                     w_accept    = 1'b1;
                     w_nextStack = {r_stack[DEPTH-2:0], r_stack[0]};
                     w_nextDepth = r_depth + DW'(1);
                  end
               end
               OP_SWAP: begin
                  if (r_depth < TWO) begin
                     w_reject = 1'b1;
                  end else begin
                     w_accept       = 1'b1;
                     w_nextStack[0] = r_stack[1];
                     w_nextStack[1] = r_stack[0];
                  end
               end
               OP_DROP: begin
                  if (r_depth == '0) begin
                     w_reject = 1'b1;
                  end else begin
                     w_accept    = 1'b1;
                     w_nextStack = w_popped;
                     w_nextDepth = r_depth - DW'(1);
                  end
               end
               default: w_reject = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stack <= '0;
         r_depth <= '0;
         r_flags <= '0;
         r_error <= 1'b0;
      end else begin
         r_error <= w_reject;
         if (w_accept || w_restore) begin
            r_stack <= w_nextStack;
            r_depth <= w_nextDepth;
            r_flags <= w_nextFlags;
         end
      end
   end

   assign Top   = (r_depth == '0) ? '0 : r_stack[0];
   assign Depth = r_depth;
   assign Flags = r_flags;
   assign Error = r_error;

endmodule

// File: tb/tb_rpn_stack_alu.sv
// Scoreboard bench for rpn_stack_alu (N=16, DEPTH=4); undo expectations follow RPN_UNDO_EN.
module tb_rpn_stack_alu;

   localparam int N     = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          Enter_pulse = 1'b0;
   logic          Undo_pulse = 1'b0;
   logic          OpSel = 1'b0;
   logic [N-1:0]  DataIn = '0;
   logic [N-1:0]  Top;
   logic [2:0]    Depth;
   logic [3:0]    Flags;
   logic          Error;

   typedef struct packed {
      logic [15:0] top;
      logic [2:0]  depth;
      logic [3:0]  flags;
      logic        err;
   } snap_t;

   snap_t expQ[$];
   snap_t obsQ[$];
   string nameQ[$];
   int    errors = 0;
   int    checks = 0;

`ifdef RPN_UNDO_EN
   localparam bit UNDO = 1'b1;
`else
   localparam bit UNDO = 1'b0;
`endif

   rpn_stack_alu #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .Enter_pulse(Enter_pulse), .Undo_pulse(Undo_pulse),
      .OpSel(OpSel), .DataIn(DataIn), .Top(Top), .Depth(Depth), .Flags(Flags), .Error(Error)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus: expected state goes in the scoreboard, observed state after the edge.
   task automatic applyStimulus(input logic ent, input logic und, input logic op,
                                input logic [15:0] data, input logic rst,
                                input logic [15:0] eTop, input logic [2:0] eDepth,
                                input logic [3:0] eFlags, input logic eErr, input string nm);
      snap_t e;
      snap_t o;
      @(negedge clk);
      Enter_pulse = ent;
      Undo_pulse  = und;
      OpSel       = op;
      DataIn      = data;
      reset       = rst;
      e = '{top: eTop, depth: eDepth, flags: eFlags, err: eErr};
      expQ.push_back(e);
      nameQ.push_back(nm);
      @(posedge clk);
      #1;
      Enter_pulse = 1'b0;
      Undo_pulse  = 1'b0;
      reset       = 1'b0;
      o = '{top: Top, depth: Depth, flags: Flags, err: Error};
      obsQ.push_back(o);
   endtask

   task automatic test_reset();
      snap_t e, o;
      string nm;
      repeat (2) @(posedge clk);
      applyStimulus(0, 0, 0, 16'h0, 1, 16'h0000, 3'd0, 4'b0000, 0, "reset_state");
      applyStimulus(0, 0, 0, 16'h0, 0, 16'h0000, 3'd0, 4'b0000, 0, "reset_idle");
      applyStimulus(0, 0, 1, 16'h0007, 0, 16'h0000, 3'd0, 4'b0000, 0, "reset_no_enter");
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got top=%h depth=%0d flags=%b err=%b, expected top=%h depth=%0d flags=%b err=%b",
                     nm, o.top, o.depth, o.flags, o.err, e.top, e.depth, e.flags, e.err);
         end
      end
   endtask

   task automatic test_arith();
      snap_t e, o;
      string nm;
      applyStimulus(0, 0, 0, 16'h0, 1, 16'h0000, 3'd0, 4'b0000, 0, "arith_reset");
      applyStimulus(1, 0, 0, 16'h0005, 0, 16'h0005, 3'd1, 4'b0000, 0, "push_5");
      applyStimulus(1, 0, 0, 16'h0003, 0, 16'h0003, 3'd2, 4'b0000, 0, "push_3");
      applyStimulus(1, 0, 1, 16'h0001, 0, 16'h0002, 3'd1, 4'b0010, 0, "sub_5_3");
      applyStimulus(0, 0, 0, 16'h0, 1, 16'h0000, 3'd0, 4'b0000, 0, "arith_reset2");
      applyStimulus(1, 0, 0, 16'h7FFF, 0, 16'h7FFF, 3'd1, 4'b0000, 0, "push_7fff");
      applyStimulus(1, 0, 0, 16'h0001, 0, 16'h0001, 3'd2, 4'b0000, 0, "push_1");
      applyStimulus(1, 0, 1, 16'h0000, 0, 16'h8000, 3'd1, 4'b1001, 0, "add_ovf");
      applyStimulus(1, 0, 1, 16'h0007, 0, 16'h0000, 3'd0, 4'b1001, 0, "drop_to_empty");
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got top=%h depth=%0d flags=%b err=%b, expected top=%h depth=%0d flags=%b err=%b",
                     nm, o.top, o.depth, o.flags, o.err, e.top, e.depth, e.flags, e.err);
         end
      end
   endtask

   task automatic test_reject();
      snap_t e, o;
      string nm;
      applyStimulus(0, 0, 0, 16'h0, 1, 16'h0000, 3'd0, 4'b0000, 0, "rej_reset");
      applyStimulus(1, 0, 1, 16'h0007, 0, 16'h0000, 3'd0, 4'b0000, 1, "drop_empty");
      applyStimulus(1, 0, 1, 16'h0005, 0, 16'h0000, 3'd0, 4'b0000, 1, "dup_empty");
      for (int i = 1; i <= 4; i++)
         applyStimulus(1, 0, 0, 16'(i * 16'h0111), 0, 16'(i * 16'h0111), 3'(i), 4'b0000, 0, "push_fill");
      applyStimulus(1, 0, 0, 16'h0555, 0, 16'h0444, 3'd4, 4'b0000, 1, "push_full");
      applyStimulus(0, 0, 0, 16'h0, 0, 16'h0444, 3'd4, 4'b0000, 0, "err_one_cycle");
      applyStimulus(1, 0, 1, 16'h0005, 0, 16'h0444, 3'd4, 4'b0000, 1, "dup_full");
      applyStimulus(1, 0, 1, 16'h000A, 0, 16'h0444, 3'd4, 4'b0000, 1, "illegal_op");
      applyStimulus(0, 0, 0, 16'h0, 0, 16'h0444, 3'd4, 4'b0000, 0, "illegal_clear");
      applyStimulus(1, 0, 1, 16'h0007, 0, 16'h0333, 3'd3, 4'b0000, 0, "drop_after_reject");
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got top=%h depth=%0d flags=%b err=%b, expected top=%h depth=%0d flags=%b err=%b",
                     nm, o.top, o.depth, o.flags, o.err, e.top, e.depth, e.flags, e.err);
         end
      end
   endtask

   task automatic test_back_to_back();
      snap_t e, o;
      string nm;
      applyStimulus(0, 0, 0, 16'h0, 1, 16'h0000, 3'd0, 4'b0000, 0, "b2b_reset");
      applyStimulus(1, 0, 0, 16'h00F0, 0, 16'h00F0, 3'd1, 4'b0000, 0, "push_00f0");
      applyStimulus(1, 0, 1, 16'h0006, 0, 16'h00F0, 3'd1, 4'b0000, 1, "swap_depth1");
      applyStimulus(1, 0, 0, 16'h8001, 0, 16'h8001, 3'd2, 4'b0000, 0, "push_8001");
      applyStimulus(1, 0, 1, 16'h0006, 0, 16'h00F0, 3'd2, 4'b0000, 0, "swap");
      applyStimulus(1, 0, 1, 16'h0005, 0, 16'h00F0, 3'd3, 4'b0000, 0, "dup");
      applyStimulus(1, 0, 1, 16'h0004, 0, 16'h0000, 3'd2, 4'b0100, 0, "xor_zero");
      applyStimulus(1, 0, 1, 16'h0003, 0, 16'h8001, 3'd1, 4'b1000, 0, "or_neg");
      applyStimulus(1, 0, 1, 16'h0002, 0, 16'h8001, 3'd1, 4'b1000, 1, "and_depth1");
      applyStimulus(1, 0, 1, 16'h0005, 0, 16'h8001, 3'd2, 4'b1000, 0, "dup2");
      applyStimulus(1, 0, 1, 16'h0001, 0, 16'h0000, 3'd1, 4'b0110, 0, "sub_equal");
      applyStimulus(1, 0, 0, 16'h0001, 0, 16'h0001, 3'd2, 4'b0110, 0, "push_1b");
      applyStimulus(1, 0, 1, 16'h0001, 0, 16'hFFFF, 3'd1, 4'b1000, 0, "sub_borrow");
      applyStimulus(1, 0, 0, 16'h8000, 0, 16'h8000, 3'd2, 4'b1000, 0, "push_8000");
      applyStimulus(1, 0, 1, 16'h0002, 0, 16'h8000, 3'd1, 4'b1000, 0, "and_mask");
      applyStimulus(1, 0, 0, 16'h0001, 0, 16'h0001, 3'd2, 4'b1000, 0, "push_1c");
      applyStimulus(1, 0, 1, 16'h0001, 0, 16'h7FFF, 3'd1, 4'b0011, 0, "sub_ovf");
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got top=%h depth=%0d flags=%b err=%b, expected top=%h depth=%0d flags=%b err=%b",
                     nm, o.top, o.depth, o.flags, o.err, e.top, e.depth, e.flags, e.err);
         end
      end
   endtask

   task automatic test_undo();
      snap_t e, o;
      string nm;
      applyStimulus(0, 0, 0, 16'h0, 1, 16'h0000, 3'd0, 4'b0000, 0, "undo_reset");
      applyStimulus(1, 0, 0, 16'hFFFF, 0, 16'hFFFF, 3'd1, 4'b0000, 0, "push_ffff");
      applyStimulus(1, 0, 0, 16'h0001, 0, 16'h0001, 3'd2, 4'b0000, 0, "push_1u");
      applyStimulus(1, 0, 1, 16'h0000, 0, 16'h0000, 3'd1, 4'b0110, 0, "add_wrap");
      applyStimulus(1, 0, 1, 16'h0007, 0, 16'h0000, 3'd0, 4'b0110, 0, "drop_u");
      applyStimulus(1, 0, 0, 16'h0010, 0, 16'h0010, 3'd1, 4'b0110, 0, "push_10");
      applyStimulus(1, 0, 0, 16'h0020, 0, 16'h0020, 3'd2, 4'b0110, 0, "push_20");
      applyStimulus(1, 0, 1, 16'h0000, 0, 16'h0030, 3'd1, 4'b0000, 0, "add_30");
      if (UNDO) begin
         applyStimulus(0, 1, 0, 16'h0, 0, 16'h0020, 3'd2, 4'b0110, 0, "undo_add");
         applyStimulus(0, 1, 0, 16'h0, 0, 16'h0020, 3'd2, 4'b0110, 1, "undo_twice");
         applyStimulus(0, 0, 0, 16'h0, 0, 16'h0020, 3'd2, 4'b0110, 0, "undo_err_clear");
      end else begin
         applyStimulus(0, 1, 0, 16'h0, 0, 16'h0030, 3'd1, 4'b0000, 0, "undo_ignored");
         applyStimulus(0, 1, 0, 16'h0, 0, 16'h0030, 3'd1, 4'b0000, 0, "undo_ignored2");
         applyStimulus(0, 0, 0, 16'h0, 0, 16'h0030, 3'd1, 4'b0000, 0, "undo_idle");
      end
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got top=%h depth=%0d flags=%b err=%b, expected top=%h depth=%0d flags=%b err=%b",
                     nm, o.top, o.depth, o.flags, o.err, e.top, e.depth, e.flags, e.err);
         end
      end
   endtask

   task automatic test_simultaneous();
      snap_t e, o;
      string nm;
      applyStimulus(0, 0, 0, 16'h0, 1, 16'h0000, 3'd0, 4'b0000, 0, "sim_reset");
      applyStimulus(1, 0, 0, 16'h0001, 0, 16'h0001, 3'd1, 4'b0000, 0, "sim_push_1");
      if (UNDO)
         applyStimulus(1, 1, 0, 16'h1234, 0, 16'h0000, 3'd0, 4'b0000, 0, "enter_and_undo");
      else
         applyStimulus(1, 1, 0, 16'h1234, 0, 16'h1234, 3'd2, 4'b0000, 0, "enter_and_undo");
      applyStimulus(0, 0, 0, 16'h0, 1, 16'h0000, 3'd0, 4'b0000, 0, "rw_reset");
      for (int i = 1; i <= 3; i++)
         applyStimulus(1, 0, 0, 16'(i), 0, 16'(i), 3'(i), 4'b0000, 0, "rw_push");
      applyStimulus(1, 0, 0, 16'h0009, 1, 16'h0000, 3'd0, 4'b0000, 0, "reset_with_enter");
      applyStimulus(0, 1, 0, 16'h0, 0, 16'h0000, 3'd0, 4'b0000, UNDO, "undo_after_reset");
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got top=%h depth=%0d flags=%b err=%b, expected top=%h depth=%0d flags=%b err=%b",
                     nm, o.top, o.depth, o.flags, o.err, e.top, e.depth, e.flags, e.err);
         end
      end
   endtask

   initial begin
      $display("[TB] rpn_stack_alu bench start (undo=%0d)", UNDO);
      test_reset();
      test_arith();
      test_reject();
      test_back_to_back();
      test_undo();
      test_simultaneous();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
